// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the asynchronous FIFO controllers.
//   PTR_AW / DEPTH : default pointer address width and the matching FIFO depth
//   ptr_t          : (PTR_AW+1)-bit pointer, one wrap bit above the address
//   bin2gray       : binary to reflected Gray code
//   gray2bin       : reflected Gray code to binary
// The conversion functions work on a 32-bit container, so any pointer width up
// to 32 bits can be passed in zero-extended and cast back to its own width.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned PTR_AW = 4;
    localparam int unsigned DEPTH  = 1 << PTR_AW;

    typedef logic [PTR_AW:0] ptr_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int unsigned i = 31; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_sync_ptr.sv
// -----------------------------------------------------------------------------
// async_sync_ptr
// Two-flop synchronizer for a Gray-coded FIFO pointer crossing into clk.
//   clk         : destination-domain clock
//   rst_n       : asynchronous active-low reset, clears both stages
//   ptr_async_i : Gray pointer from the other clock domain
//   ptr_sync_o  : pointer after two clk flops
// -----------------------------------------------------------------------------
module async_sync_ptr #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   ptr_async_i,
    output logic [ADDR_WIDTH:0]   ptr_sync_o
);

    logic [ADDR_WIDTH:0] meta_q;
    logic [ADDR_WIDTH:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ptr_async_i;
            sync_q <= meta_q;
        end
    end

    assign ptr_sync_o = sync_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
// Write-side controller of the asynchronous FIFO (write clock domain only).
//   clk          : write-domain clock
//   rst_n        : asynchronous active-low reset
//   wr_en        : producer write request
//   rd_ptr_gray  : Gray read pointer from the read domain (unsynchronized)
//   ovf_clr      : single-cycle clear of overflow
//   wr_accept    : RAM write enable (wr_en while not full)
//   waddr        : RAM write address
//   wr_ptr_gray  : registered Gray write pointer for the read-side synchronizer
//   full         : registered full flag
//   almost_full  : registered, level of the next state >= AFULL_THRESH
//   wr_level     : pessimistic occupancy estimate, 0..DEPTH
//   overflow     : sticky, set by a write attempt while full
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    input  logic                  ovf_clr,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    import async_fifo_pkg::*;

    localparam int unsigned AW = ADDR_WIDTH;

    typedef logic [AW:0] wptr_t;

    wptr_t wbin_q, wbin_d;
    wptr_t wgray_q, wgray_d;
    wptr_t rq2, rbin_s;
    wptr_t full_cmp, lvl_next;
    logic  full_q, full_d;
    logic  afull_q, afull_d;
    logic  ovf_q, ovf_d;

    async_sync_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sync_rptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .ptr_async_i (rd_ptr_gray),
        .ptr_sync_o  (rq2)
    );

    always_comb begin
        // Gated by rst_n so no RAM write can be issued while reset is held.
        wr_accept = wr_en & ~full_q & rst_n;
        wbin_d    = wbin_q + wptr_t'(wr_accept);
        wgray_d   = wptr_t'(bin2gray(32'(wbin_d)));
        rbin_s    = wptr_t'(gray2bin(32'(rq2)));
        // Full when the next write pointer is exactly one lap ahead of the
        // synchronized read pointer: in Gray code that inverts the top two bits.
        full_cmp  = {~rq2[AW:AW-1], rq2[AW-2:0]};
        full_d    = (wgray_d == full_cmp);
        lvl_next  = wbin_d - rbin_s;
        afull_d   = (lvl_next >= wptr_t'(AFULL_THRESH));
        // Set has priority over clear.
        ovf_d     = (wr_en & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = wbin_q[AW-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign wr_level    = wbin_q - rbin_s;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_ctrl
// Scoreboard bench for async_fifo_wr_ctrl. The driver steps an occupancy-level
// reference model once per clock and queues the outputs the DUT must show in
// that cycle; an independent monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_ctrl;

    localparam int AW = 4;
    localparam int D  = 16;
    localparam int TH = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   rd_ptr_gray = '0;
    logic          wr_accept, full, almost_full, overflow;
    logic [AW-1:0] waddr;
    logic [AW:0]   wr_ptr_gray, wr_level;

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_ptr_gray (rd_ptr_gray),
        .ovf_clr     (ovf_clr),
        .wr_accept   (wr_accept),
        .waddr       (waddr),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int addr;
        int gray;
        int full;
        int afull;
        int level;
        int ovf;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: write count modulo 2*D, the read count as seen through
    // two write-clock stages, and the flags.
    int m_wb, m_s1, m_s2;
    int m_full, m_afull, m_ovf;
    int c_we, c_clr, c_rd;

    function automatic int g(int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int occ(int w, int r);
        return (w - r + 4 * D) % (2 * D);
    endfunction

    task automatic chk(string name, logic [31:0] act, int exp);
        compared++;
        if (act !== 32'(exp)) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_wb = 0; m_s1 = 0; m_s2 = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
        c_we = 0; c_clr = 0; c_rd = 0;
    endfunction

    function automatic void model_edge();
        int acc;
        int wn;
        acc     = (c_we != 0 && m_full == 0) ? 1 : 0;
        wn      = (m_wb + acc) % (2 * D);
        m_ovf   = ((c_we != 0 && m_full != 0) || (m_ovf != 0 && c_clr == 0)) ? 1 : 0;
        m_full  = (occ(wn, m_s2) == D) ? 1 : 0;
        m_afull = (occ(wn, m_s2) >= TH) ? 1 : 0;
        m_s2    = m_s1;
        m_s1    = c_rd;
        m_wb    = wn;
    endfunction

    task automatic step(int we, int clr, int rd);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        c_we = we; c_clr = clr; c_rd = rd;
        wr_en       = (we != 0);
        ovf_clr     = (clr != 0);
        rd_ptr_gray = (AW+1)'(g(rd));
        e.acc   = (we != 0 && m_full == 0) ? 1 : 0;
        e.addr  = m_wb % D;
        e.gray  = g(m_wb);
        e.full  = m_full;
        e.afull = m_afull;
        e.level = occ(m_wb, m_s2);
        e.ovf   = m_ovf;
        sbq.push_back(e);
    endtask

    // Outputs must be zero while reset is held, before any clock edge.
    task automatic async_reset();
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("rst_wr_accept", 32'(wr_accept), 0);
        chk("rst_waddr", 32'(waddr), 0);
        chk("rst_wr_ptr_gray", 32'(wr_ptr_gray), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_wr_level", 32'(wr_level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wr_accept", 32'(wr_accept), e.acc);
            chk("waddr", 32'(waddr), e.addr);
            chk("wr_ptr_gray", 32'(wr_ptr_gray), e.gray);
            chk("full", 32'(full), e.full);
            chk("almost_full", 32'(almost_full), e.afull);
            chk("wr_level", 32'(wr_level), e.level);
            chk("overflow", 32'(overflow), e.ovf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdv;
        #2;
        async_reset();

        // Fill from empty with the read pointer parked at 0.
        repeat (D) step(1, 0, 0);
        step(0, 0, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(wr_level), 16);
        chk("fill_afull", 32'(almost_full), 1);
        chk("fill_gray", 32'(wr_ptr_gray), 'h18);

        // Overflow: attempts while full, clear alone, clear colliding with set.
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_ptr_hold", 32'(wr_ptr_gray), 'h18);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("ovf_clr", 32'(overflow), 0);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("ovf_set_wins", 32'(overflow), 1);
        step(0, 1, 0);
        step(0, 0, 0);

        // Read release: one entry freed, then refill it.
        repeat (4) step(0, 0, 1);
        chk("rel_full", 32'(full), 0);
        chk("rel_level", 32'(wr_level), 15);
        step(1, 0, 1);
        step(0, 0, 1);
        chk("rel_refull", 32'(full), 1);

        // Wrap: reads advance to 16 while writing until wbin comes back to 0.
        for (int k = 2; k <= 16; k++) step(1, 0, k);
        repeat (8) step(1, 0, 16);
        step(0, 0, 16);
        chk("wrap_gray", 32'(wr_ptr_gray), 0);
        chk("wrap_full", 32'(full), 1);
        chk("wrap_waddr", 32'(waddr), 0);
        step(0, 1, 16);

        // Random traffic; the reader never passes what has been written.
        rdv = 16;
        repeat (500) begin
            int we;
            int clr;
            we  = (($urandom % 4) != 0) ? 1 : 0;
            clr = (($urandom % 8) == 0) ? 1 : 0;
            if (($urandom % 2) != 0 && occ(m_wb, rdv) > 0) rdv = (rdv + 1) % (2 * D);
            step(we, clr, rdv);
        end

        // Reset in the middle of a burst at level 7.
        @(posedge clk);
        #2;
        async_reset();
        repeat (7) step(1, 0, 0);
        step(1, 0, 0);
        chk("mid_level7", 32'(wr_level), 7);
        #2;
        async_reset();
        step(1, 0, 0);
        chk("post_rst_waddr", 32'(waddr), 0);
        step(0, 0, 0);
        chk("post_rst_gray", 32'(wr_ptr_gray), 1);
        step(0, 0, 0);

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
